// File: rtl/float_point_mul_seq_pkg.sv
// Shared constants and types for the iterative single-precision multiplier.
// Field widths, special encodings, operand classes and FSM states.
package fp_pkg;
   localparam int MANT_W = 23;
   localparam int EXP_W  = 8;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

   typedef enum logic [2:0] {S_IDLE, S_MULT, S_NORM, S_ROUND, S_DONE} state_e;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W:0]   sig;
      fp_class_e         cls;
   } fp_unpk_t;
endpackage

// File: rtl/float_point_mul_seq_if.sv
// Operand/result handshake bundle for the iterative multiplier.
interface float_point_mul_seq_if;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] out;
   logic        ovf;
   logic        unf;
   logic        inv;

   modport master (output start, A, B, input busy, done, out, ovf, unf, inv);
   modport slave  (input start, A, B, output busy, done, out, ovf, unf, inv);
endinterface

// File: rtl/float_point_mul_seq_classify.sv
// Combinational unpack of one single-precision operand into sign/exp/significand/class.
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0] op,
   output fp_unpk_t    unpk
);
   logic [EXP_W-1:0]  exp;
   logic [MANT_W-1:0] frac;

   assign exp  = op[30:23];
   assign frac = op[22:0];

   always_comb begin
      unpk.sign = op[31];
      unpk.exp  = exp;
      unpk.sig  = {1'b1, frac};
      unpk.cls  = NORM;
      // Denormals are flushed: treated as zero with no hidden bit.
      if (exp == '0) begin
         unpk.cls = ZERO;
         unpk.sig = '0;
      end else if (exp == '1) begin
         unpk.cls = (frac == '0) ? INF : NAN;
      end
   end
endmodule

// File: rtl/float_point_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier: 24-cycle radix-2 shift-add,
// then normalise, round-to-nearest-even and pack; fixed 27-cycle latency.
module float_point_mul_seq
   import fp_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   float_point_mul_seq_if.slave   bus
);
   localparam int SIG_W = MANT_W + 1;
   localparam int PRD_W = 2 * SIG_W;

   fp_unpk_t ua, ub;

   fp_classify u_cls_a (.op(bus.A), .unpk(ua));
   fp_classify u_cls_b (.op(bus.B), .unpk(ub));

   state_e state, state_nxt;
   logic   accept;

   logic [4:0]        cnt;
   logic [PRD_W-1:0]  mcand;
   logic [SIG_W-1:0]  mplier;
   logic [PRD_W-1:0]  acc;
   logic              sign_r;
   fp_class_e         cls_a, cls_b;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic signed [9:0] e_r;
   logic [MANT_W-1:0] frac_r;
   logic              g_r, s_r;

   logic [31:0] out_r;
   logic        ovf_r, unf_r, inv_r;
   logic        busy_c, done_c;

   assign accept = bus.start && (state == S_IDLE || state == S_DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_MULT;
         S_MULT:  if (cnt == 5'(SIG_W - 1)) state_nxt = S_NORM;
         S_NORM:  state_nxt = S_ROUND;
         S_ROUND: state_nxt = S_DONE;
         S_DONE:  state_nxt = accept ? S_MULT : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         S_MULT, S_NORM, S_ROUND: busy_c = 1'b1;
         S_DONE:                  done_c = 1'b1;
         default: ;
      endcase
   end

   // Rounding and range/special resolution, consumed on the ROUND->DONE edge.
   logic              inc, carry;
   logic [MANT_W-1:0] frac_rnd;
   logic signed [9:0] e_rnd;
   logic              nan_op, zero_inf, any_inf, any_zero;
   logic [31:0]       res;
   logic              res_ovf, res_unf, res_inv;

   always_comb begin
      inc               = g_r & (s_r | frac_r[0]);
      {carry, frac_rnd} = {1'b0, frac_r} + (MANT_W+1)'(inc);
      e_rnd             = e_r + $signed({9'b0, carry});

      nan_op   = (cls_a == NAN) || (cls_b == NAN);
      zero_inf = (cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO);
      any_inf  = (cls_a == INF) || (cls_b == INF);
      any_zero = (cls_a == ZERO) || (cls_b == ZERO);

      res     = {sign_r, e_rnd[EXP_W-1:0], frac_rnd};
      res_ovf = 1'b0;
      res_unf = 1'b0;
      res_inv = 1'b0;
      if (nan_op || zero_inf) begin
         res     = QNAN;
         res_inv = 1'b1;
      end else if (any_inf) begin
         res = {sign_r, POS_INF[30:0]};
      end else if (any_zero) begin
         res = {sign_r, 31'b0};
      end else if (e_rnd >= 10'sd255) begin
         res     = {sign_r, POS_INF[30:0]};
         res_ovf = 1'b1;
      end else if (e_rnd <= 10'sd0) begin
         res     = {sign_r, 31'b0};
         res_unf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         sign_r <= 1'b0;
         cls_a  <= ZERO;
         cls_b  <= ZERO;
         exp_a  <= '0;
         exp_b  <= '0;
         e_r    <= '0;
         frac_r <= '0;
         g_r    <= 1'b0;
         s_r    <= 1'b0;
         out_r  <= '0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
         inv_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (accept) begin
               cnt    <= '0;
               mcand  <= {{SIG_W{1'b0}}, ua.sig};
               mplier <= ub.sig;
               acc    <= '0;
               sign_r <= ua.sign ^ ub.sign;
               cls_a  <= ua.cls;
               cls_b  <= ub.cls;
               exp_a  <= ua.exp;
               exp_b  <= ub.exp;
            end
            S_MULT: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
            end
            S_NORM: begin
               e_r <= $signed({2'b0, exp_a}) + $signed({2'b0, exp_b})
                      - $signed(10'(BIAS)) + $signed({9'b0, acc[PRD_W-1]});
               if (acc[PRD_W-1]) begin
                  frac_r <= acc[46:24];
                  g_r    <= acc[23];
                  s_r    <= |acc[22:0];
               end else begin
                  frac_r <= acc[45:23];
                  g_r    <= acc[22];
                  s_r    <= |acc[21:0];
               end
            end
            S_ROUND: begin
               out_r <= res;
               ovf_r <= res_ovf;
               unf_r <= res_unf;
               inv_r <= res_inv;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.out  = out_r;
   assign bus.ovf  = ovf_r;
   assign bus.unf  = unf_r;
   assign bus.inv  = inv_r;
endmodule

// File: tb/tb_float_point_mul_seq.sv
// Directed bench for float_point_mul_seq: arithmetic, rounding, range, specials, handshake, reset.
module tb_float_point_mul_seq;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   lat;
   int   dones;

   always #5 clk = ~clk;

   float_point_mul_seq_if bus ();

   float_point_mul_seq dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // n counts cycles with the accepting edge opening cycle 1; bounded.
   task automatic wait_done(output int n);
      n = 1;
      while (bus.done !== 1'b1 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_out, input logic [2:0] exp_flags);
      launch(a, b);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(lat);
      chk({tag, "_lat"}, lat, 32'd27);
      chk(tag, bus.out, exp_out);
      chk({tag, "_flags"}, 32'({bus.ovf, bus.unf, bus.inv}), 32'(exp_flags));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_out", bus.out, 32'h0);
      chk("rst_flags", 32'({bus.ovf, bus.unf, bus.inv}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // flags order: {ovf, unf, inv}
      op("two_x_three", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);
      op("onep5_sq",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000);
      op("one_x_neg1",  32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 3'b000);
      op("sticky_only", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000);
      op("p47_norm",    32'h3F80_0001, 32'h3FFF_FFFF, 32'h4000_0000, 3'b000);
      op("tie_odd_up",  32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000);
      op("tie_even",    32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 3'b000);
      op("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100);
      op("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010);
      op("zero_x_inf",  32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001);
      op("ninf_x_two",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000);
      op("nan_x_one",   32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001);
      op("nzero_x_fin", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000);

      // start pulses during busy are ignored
      launch(32'h4000_0000, 32'h4040_0000);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 60) begin
         if (lat == 5 || lat == 10) begin
            bus.A     = 32'h3F80_0000;
            bus.B     = 32'hBF80_0000;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      chk("ign_lat", lat, 32'd27);
      chk("ign_out", bus.out, 32'h40C0_0000);
      dones = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dones++;
      end
      chk("ign_extra_done", dones, 32'd0);

      // back-to-back: second start accepted on the done cycle
      launch(32'h3F80_0000, 32'hBF80_0000);
      wait_done(lat);
      chk("b2b_first", bus.out, 32'hBF80_0000);
      launch(32'h3FC0_0000, 32'h3FC0_0000);
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      chk("b2b_held", bus.out, 32'hBF80_0000);
      wait_done(lat);
      chk("b2b_lat", lat, 32'd27);
      chk("b2b_second", bus.out, 32'h4010_0000);
      @(posedge clk); #1;

      // asynchronous reset in the middle of MULT
      launch(32'h4000_0000, 32'h4040_0000);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      chk("mid_rst_out", bus.out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      dones = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dones++;
      end
      chk("mid_rst_no_done", dones, 32'd0);
      op("post_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
